// File: rtl/hazard_pkg.sv
// Shared constants and the per-lane issue request record for the hazard scoreboard.
package hazard_pkg;

  // Default latency field width and the largest latency it can express.
  localparam int DEF_LAT_W = 3;
  localparam int MAX_LAT   = (1 << DEF_LAT_W) - 1;

  // Field widths inside the request record are sized for the largest build;
  // narrower register indices and latencies are zero-extended into them.
  localparam int RW_MAX    = 8;
  localparam int LAT_W_MAX = 8;

  // Source operand slots per lane: 0 = a, 1 = b, 2 = s.
  localparam int NSRC = 3;

  typedef struct packed {
    logic [NSRC-1:0][RW_MAX-1:0] srcs;
    logic [NSRC-1:0]             src_used;
    logic [RW_MAX-1:0]           rt;
    logic                        rt_flag;
    logic [LAT_W_MAX-1:0]        lat;
  } lane_req_t;

endpackage

// File: rtl/hazard_reg_counter.sv
// One register's pending-write countdown: load on issue, count down to zero,
// freeze while downstream holds. busy means a write is still in flight.
module hazard_reg_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_reg;

  // Countdown state: a fresh load wins over the decrement; hold freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - LAT_W'(1);
      end
    end
  end

  assign cnt  = cnt_reg;
  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: one countdown per GPR, combinational RAW/WAW
// detection across the bundle and against in-flight writes, all-or-nothing issue.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int LANES = 2,
  parameter int NREG  = 32,
  parameter int LAT_W = DEF_LAT_W,
  localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [LANES-1:0]       issue_valid,
  input  logic [LANES*RW-1:0]    src_a,
  input  logic [LANES*RW-1:0]    src_b,
  input  logic [LANES*RW-1:0]    src_s,
  input  logic [LANES*NSRC-1:0]  src_used,
  input  logic [LANES*RW-1:0]    rt,
  input  logic [LANES-1:0]       rt_flag,
  input  logic [LANES*LAT_W-1:0] lat,
  output logic                   interlock,
  output logic [LANES-1:0]       lane_accept,
  output logic [NREG-1:0]        busy
);

  lane_req_t            lane_req [LANES];
  logic [LAT_W_MAX-1:0] lat_m1   [LANES];
  logic [LAT_W-1:0]     cnt_arr  [NREG];
  logic [NREG-1:0]      load_en;
  logic [LAT_W-1:0]     load_val [NREG];
  logic                 hazard;

  // Gather each lane's flat port slices into one request record. The counter
  // is loaded with lat-1 so a dependent issues exactly lat cycles later; a
  // latency of zero behaves like one.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_req[gi] = '{
      srcs:     {RW_MAX'(src_s[gi*RW +: RW]),
                 RW_MAX'(src_b[gi*RW +: RW]),
                 RW_MAX'(src_a[gi*RW +: RW])},
      src_used: src_used[gi*NSRC +: NSRC],
      rt:       RW_MAX'(rt[gi*RW +: RW]),
      rt_flag:  rt_flag[gi],
      lat:      LAT_W_MAX'(lat[gi*LAT_W +: LAT_W])
    };
    assign lat_m1[gi] = (lane_req[gi].lat == '0) ? '0 : lane_req[gi].lat - LAT_W_MAX'(1);
  end

  // Hazard detection: reads of busy registers, reads of an older lane's
  // destination, writes that would overtake an in-flight write, and two
  // writers to the same register in one bundle.
  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (issue_valid[j]) begin
        for (int s = 0; s < NSRC; s++) begin
          if (lane_req[j].src_used[s]) begin
            for (int r = 0; r < NREG; r++) begin
              if (lane_req[j].srcs[s] == RW_MAX'(r) && busy[r]) hazard = 1'b1;
            end
            for (int i = 0; i < j; i++) begin
              if (issue_valid[i] && lane_req[i].rt_flag &&
                  lane_req[i].rt == lane_req[j].srcs[s]) hazard = 1'b1;
            end
          end
        end
        if (lane_req[j].rt_flag) begin
          for (int r = 0; r < NREG; r++) begin
            if (lane_req[j].rt == RW_MAX'(r) &&
                LAT_W_MAX'(cnt_arr[r]) > lat_m1[j]) hazard = 1'b1;
          end
          for (int i = 0; i < j; i++) begin
            if (issue_valid[i] && lane_req[i].rt_flag &&
                lane_req[i].rt == lane_req[j].rt) hazard = 1'b1;
          end
        end
      end
    end
  end

  // Reset and downstream back-pressure block issue just like a hazard.
  assign interlock   = rst | hold | hazard;
  assign lane_accept = issue_valid & {LANES{~interlock}};

  // Load select: route each accepted writing lane's latency to its register.
  // At most one lane can target a register, as same-rt bundles are interlocked.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      load_en[r]  = 1'b0;
      load_val[r] = '0;
      for (int j = 0; j < LANES; j++) begin
        if (lane_accept[j] && lane_req[j].rt_flag && lane_req[j].rt == RW_MAX'(r)) begin
          load_en[r]  = 1'b1;
          load_val[r] = LAT_W'(lat_m1[j]);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    hazard_reg_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .load     (load_en[gi]),
      .load_val (load_val[gi]),
      .cnt      (cnt_arr[gi]),
      .busy     (busy[gi])
    );
  end

endmodule
